// File: rtl/cclut_pkg.sv
// Shared constants, LUT word field layout and default table contents for the
// CCLUT pattern lookup blocks.
package cclut_pkg;

  localparam int MXPIDB = 3;
  localparam int MXDATB = 9;
  localparam int MXPATC = 11;

  localparam int BEND_LSB    = 0;
  localparam int BEND_W      = 5;
  localparam int OFFS_LSB    = 5;
  localparam int OFFS_W      = 4;
  localparam int OFFS_CENTER = 7;

  localparam int NPID = 5;

  // Centred offset, zero bend: returned for out-of-range pattern IDs.
  localparam logic [MXDATB-1:0] LUT_BLANK = 9'b0111_00000;

  // Power-up table contents: offset = adr[3:0], bend = adr[8:4] ^ pid.
  // The mem-file flow replaces these words with the fitted table contents.
  function automatic logic [MXDATB-1:0] lut_default(input int pid, input int adr);
    logic [MXDATB-1:0] w;
    w = '0;
    w[OFFS_LSB +: OFFS_W] = OFFS_W'(adr);
    w[BEND_LSB +: BEND_W] = BEND_W'(adr >> OFFS_W) ^ BEND_W'(pid);
    return w;
  endfunction

endpackage

// File: rtl/cclut_pattern_lut_pipe_table.sv
// One pattern table with NCH registered read ports; writable at run time when
// CCLUT_LUT_WRITE_EN is defined, otherwise a read-only ROM.
module cclut_table #(
  parameter int NCH = 2,
  parameter int PID = 0,
  parameter int AW  = cclut_pkg::MXPATC,
  parameter int DW  = cclut_pkg::MXDATB
) (
  input  logic              clock,
  input  logic [NCH-1:0]    rd_en,
  input  logic [NCH*AW-1:0] rd_adr,
  output logic [NCH*DW-1:0] rd_data
`ifdef CCLUT_LUT_WRITE_EN
  ,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_adr,
  input  logic [DW-1:0]     wr_data
`endif
);
  import cclut_pkg::*;

`ifdef CCLUT_LUT_WRITE_EN
  // Written words overlay the power-up contents; the flag vector tracks which
  // addresses have been overwritten so reset never touches the table.
  logic [DW-1:0]    mem [2**AW];
  logic [2**AW-1:0] written = '0;

  always_ff @(posedge clock)
    if (wr_en) begin
      mem[wr_adr]     <= wr_data;
      written[wr_adr] <= 1'b1;
    end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_port
    logic [AW-1:0] adr;
    logic [DW-1:0] q;

    assign adr = rd_adr[c*AW +: AW];

    always_ff @(posedge clock)
      if (rd_en[c])
`ifdef CCLUT_LUT_WRITE_EN
        q <= written[adr] ? mem[adr] : DW'(lut_default(PID, int'(adr)));
`else
        q <= DW'(lut_default(PID, int'(adr)));
`endif

    assign rd_data[c*DW +: DW] = q;
  end

endmodule

// File: rtl/cclut_pattern_lut_pipe.sv
// Pipelined NCH-channel CCLUT lookup: comparator code -> offset/bend -> refined
// half-strip and eighth-strip keys. CCLUT_LUT_WRITE_EN adds a table write port.
module cclut_pattern_lut_pipe #(
  parameter int NCH        = 2,
  parameter int MXKEYBX    = 8,
  parameter int MXPATC     = cclut_pkg::MXPATC,
  parameter int MXPIDB     = cclut_pkg::MXPIDB,
  parameter int MXDATB     = cclut_pkg::MXDATB,
  parameter int NHS        = 224,
  parameter     ROM_PREFIX = "rom_pat"
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NCH-1:0]             in_vld,
  input  logic [NCH*MXKEYBX-1:0]     in_key,
  input  logic [NCH*MXPIDB-1:0]      in_pid,
  input  logic [NCH*MXPATC-1:0]      in_cc,
`ifdef CCLUT_LUT_WRITE_EN
  input  logic                       lut_we,
  input  logic [MXPIDB-1:0]          lut_pid,
  input  logic [MXPATC-1:0]          lut_adr,
  input  logic [MXDATB-1:0]          lut_wdata,
`endif
  output logic [NCH-1:0]             out_vld,
  output logic [NCH*MXKEYBX-1:0]     out_key,
  output logic [NCH*(MXKEYBX+2)-1:0] out_eskey,
  output logic [NCH*4-1:0]           out_offs,
  output logic [NCH*5-1:0]           out_bend,
  output logic [NCH-1:0]             out_badpid,
  output logic [NCH-1:0]             out_clip
);
  import cclut_pkg::*;

  localparam int ESW    = MXKEYBX + 2;
  localparam int ESX    = MXKEYBX + 3;
  localparam int ES_MAX = 4*NHS - 1;

  // [1] input capture, [2] LUT data, [3] output register
  logic [3:1][NCH-1:0]     vld_pipe;
  logic [NCH*MXPATC-1:0]   lut_adr_s1;
  logic [NCH*MXDATB-1:0]   lut_q [NPID];

  always_ff @(posedge clock)
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[2:1], in_vld};

  assign out_vld = vld_pipe[3];

  for (genvar p = 0; p < NPID; p++) begin : g_tab
    cclut_table #(.NCH(NCH), .PID(p), .AW(MXPATC), .DW(MXDATB)) u_tab (
      .clock   (clock),
      .rd_en   (vld_pipe[1]),
      .rd_adr  (lut_adr_s1),
`ifdef CCLUT_LUT_WRITE_EN
      .wr_en   (lut_we && (lut_pid == MXPIDB'(p))),
      .wr_adr  (lut_adr),
      .wr_data (lut_wdata),
`endif
      .rd_data (lut_q[p])
    );
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [MXKEYBX-1:0]    key1, key2, okey;
    logic [MXPIDB-1:0]     pid1, pid2;
    logic [MXPATC-1:0]     cc1;
    logic [MXDATB-1:0]     word;
    logic                  bad, clip;
    logic signed [ESX-1:0] es;
    logic [ESW-1:0]        es_sat, oes;
    logic [OFFS_W-1:0]     ooffs;
    logic [BEND_W-1:0]     obend;
    logic                  obad, oclip;

    // Data registers only load on a valid candidate; idle cycles cost no toggles.
    always_ff @(posedge clock) begin
      if (in_vld[c]) begin
        key1 <= in_key[c*MXKEYBX +: MXKEYBX];
        pid1 <= in_pid[c*MXPIDB +: MXPIDB];
        cc1  <= in_cc[c*MXPATC +: MXPATC];
      end
      if (vld_pipe[1][c]) begin
        key2 <= key1;
        pid2 <= pid1;
      end
    end

    assign lut_adr_s1[c*MXPATC +: MXPATC] = cc1;

    always_comb begin
      word = LUT_BLANK;
      bad  = 1'b1;
      for (int p = 0; p < NPID; p++)
        if (int'(pid2) == p) begin
          word = lut_q[p][c*MXDATB +: MXDATB];
          bad  = 1'b0;
        end
      es = $signed({1'b0, key2, 2'b00})
         + $signed(ESX'(word[OFFS_LSB +: OFFS_W]))
         - $signed(ESX'(OFFS_CENTER));
      es_sat = es[ESW-1:0];
      clip   = 1'b0;
      if (es[ESX-1]) begin
        es_sat = '0;
        clip   = 1'b1;
      end else if (es > $signed(ESX'(ES_MAX))) begin
        es_sat = ESW'(ES_MAX);
        clip   = 1'b1;
      end
    end

    always_ff @(posedge clock)
      if (reset) begin
        okey  <= '0;
        oes   <= '0;
        ooffs <= '0;
        obend <= '0;
        obad  <= 1'b0;
        oclip <= 1'b0;
      end else if (vld_pipe[2][c]) begin
        okey  <= es_sat[ESW-1:2];
        oes   <= es_sat;
        ooffs <= word[OFFS_LSB +: OFFS_W];
        obend <= word[BEND_LSB +: BEND_W];
        obad  <= bad;
        oclip <= clip;
      end

    assign out_key[c*MXKEYBX +: MXKEYBX] = okey;
    assign out_eskey[c*ESW +: ESW]       = oes;
    assign out_offs[c*4 +: 4]            = ooffs;
    assign out_bend[c*5 +: 5]            = obend;
    assign out_badpid[c]                 = obad;
    assign out_clip[c]                   = oclip;
  end

endmodule

// File: tb/tb_cclut_pattern_lut_pipe.sv
// Directed bench for cclut_pattern_lut_pipe: an abstract result model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_cclut_pattern_lut_pipe;
  localparam int NCH = 2, KB = 8, PB = 3, CB = 11, DB = 9, NHS = 224;
  localparam int ESW = KB + 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_vld;
  logic [NCH*KB-1:0]    in_key;
  logic [NCH*PB-1:0]    in_pid;
  logic [NCH*CB-1:0]    in_cc;
  logic [NCH-1:0]       out_vld, out_badpid, out_clip;
  logic [NCH*KB-1:0]    out_key;
  logic [NCH*ESW-1:0]   out_eskey;
  logic [NCH*4-1:0]     out_offs;
  logic [NCH*5-1:0]     out_bend;
`ifdef CCLUT_LUT_WRITE_EN
  logic                 lut_we = 1'b0;
  logic [PB-1:0]        lut_pid = '0;
  logic [CB-1:0]        lut_adr = '0;
  logic [DB-1:0]        lut_wdata = '0;
`endif

  always #5 clock = ~clock;

  cclut_pattern_lut_pipe #(.NCH(NCH), .MXKEYBX(KB), .NHS(NHS)) dut (
    .clock(clock), .reset(reset),
    .in_vld(in_vld), .in_key(in_key), .in_pid(in_pid), .in_cc(in_cc),
`ifdef CCLUT_LUT_WRITE_EN
    .lut_we(lut_we), .lut_pid(lut_pid), .lut_adr(lut_adr), .lut_wdata(lut_wdata),
`endif
    .out_vld(out_vld), .out_key(out_key), .out_eskey(out_eskey), .out_offs(out_offs),
    .out_bend(out_bend), .out_badpid(out_badpid), .out_clip(out_clip)
  );

  int checks = 0, errors = 0;
  bit model_on = 1'b0;

  typedef struct { bit vld; int key, es, offs, bend; bit bad, clip; } res_t;
  typedef struct { bit vld; int key, pid, cc; } raw_t;
  raw_t s0 [NCH];
  res_t s1 [NCH];
  res_t expo [NCH];
  int   wr_tab [int];

  // Table contents: offset = cc[3:0], bend = cc[8:4] ^ pid unless overwritten.
  function automatic res_t compute(input int key, input int pid, input int cc);
    res_t r = '{default:0};
    int k;
    k = pid*4096 + cc;
    if (pid > 4) begin r.offs = 7; r.bend = 0; r.bad = 1; end
    else if (wr_tab.exists(k)) begin r.offs = wr_tab[k] >> 5; r.bend = wr_tab[k] & 31; end
    else begin r.offs = cc & 15; r.bend = ((cc >> 4) & 31) ^ pid; end
    r.es = key*4 + r.offs - 7;
    if (r.es < 0) begin r.es = 0; r.clip = 1; end
    else if (r.es > 4*NHS-1) begin r.es = 4*NHS-1; r.clip = 1; end
    r.key = r.es / 4;
    r.vld = 1;
    return r;
  endfunction

  // Candidate captured at edge N is looked up at N+1 and shown from N+2;
  // a channel's data holds while no valid candidate arrives.
  always @(posedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        s0[c] = '{default:0}; s1[c] = '{default:0}; expo[c] = '{default:0};
      end else begin
        expo[c].vld = s1[c].vld;
        if (s1[c].vld) expo[c] = s1[c];
        s1[c].vld = s0[c].vld;
        if (s0[c].vld) s1[c] = compute(s0[c].key, s0[c].pid, s0[c].cc);
        s0[c].vld = in_vld[c];
        if (in_vld[c]) begin
          s0[c].key = int'(in_key[c*KB +: KB]);
          s0[c].pid = int'(in_pid[c*PB +: PB]);
          s0[c].cc  = int'(in_cc[c*CB +: CB]);
        end
      end
    end
`ifdef CCLUT_LUT_WRITE_EN
    if (lut_we && lut_pid <= 4) wr_tab[int'(lut_pid)*4096 + int'(lut_adr)] = int'(lut_wdata);
`endif
  end

  always @(negedge clock) begin : cmp
    logic [29:0] a, e;
    if (model_on)
      for (int c = 0; c < NCH; c++) begin
        a = {out_vld[c], out_key[c*KB +: KB], out_eskey[c*ESW +: ESW], out_offs[c*4 +: 4],
             out_bend[c*5 +: 5], out_badpid[c], out_clip[c]};
        e = {expo[c].vld, KB'(expo[c].key), ESW'(expo[c].es), 4'(expo[c].offs),
             5'(expo[c].bend), expo[c].bad, expo[c].clip};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model ch%0d t=%0t got vld/key/es/offs/bend/bad/clip=%0d/%0d/%0d/%0d/%h/%0d/%0d want %0d/%0d/%0d/%0d/%h/%0d/%0d",
                   c, $time, a[29], a[28:21], a[20:11], a[10:7], a[6:2], a[1], a[0],
                   e[29], e[28:21], e[20:11], e[10:7], e[6:2], e[1], e[0]);
        end
      end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input int key, input int pid, input int cc);
    in_vld[c] = 1'b1;
    in_key[c*KB +: KB] = KB'(key);
    in_pid[c*PB +: PB] = PB'(pid);
    in_cc[c*CB +: CB]  = CB'(cc);
  endtask

  task automatic idle(input int n);
    in_vld = '0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; in_vld = '0; in_key = '0; in_pid = '0; in_cc = '0;
    @(posedge clock);
    model_on = 1'b1;
    @(negedge clock);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_eskey", int'(out_eskey), 0);
    chk("rst_bend", int'(out_bend), 0);
    reset = 1'b0;

    // single candidate, pid 4, centred offset
    @(negedge clock); drive(0, 100, 4, 'h177);
    @(negedge clock); in_vld = '0;
    @(negedge clock); chk("lat_early_vld", int'(out_vld[0]), 0);
    @(negedge clock);
    chk("t1_vld", int'(out_vld[0]), 1);
    chk("t1_key", int'(out_key[KB-1:0]), 100);
    chk("t1_eskey", int'(out_eskey[ESW-1:0]), 400);
    chk("t1_offs", int'(out_offs[3:0]), 7);
    chk("t1_bend", int'(out_bend[4:0]), 'h13);
    chk("t1_clip", int'(out_clip[0]), 0);
    idle(3);

    // offset sweep on ch0, parallel traffic on ch1
    for (int i = 0; i < 19; i++) begin
      if (i >= 3) begin
        chk("sweep_vld", int'(out_vld[0]), 1);
        chk("sweep_eskey", int'(out_eskey[ESW-1:0]), 193 + i - 3);
        chk("sweep_key", int'(out_key[KB-1:0]), (193 + i - 3) / 4);
      end
      if (i < 16) begin drive(0, 50, 1, i); drive(1, 10 + i, 2, 'h3A0 + i); end
      else in_vld = '0;
      @(negedge clock);
    end
    idle(3);

    // clamp at both ends of the strip range
    drive(0, 0, 0, 'h000); drive(1, NHS-1, 0, 'h00F);
    @(negedge clock); idle(2);
    chk("clip_lo_eskey", int'(out_eskey[ESW-1:0]), 0);
    chk("clip_lo", int'(out_clip[0]), 1);
    chk("clip_hi_eskey", int'(out_eskey[ESW +: ESW]), 895);
    chk("clip_hi_key", int'(out_key[KB +: KB]), 223);
    chk("clip_hi", int'(out_clip[1]), 1);
    idle(3);

    // bad pid on ch1 only
    drive(0, 30, 2, 'h2A5); drive(1, 40, 6, 'h123);
    @(negedge clock); idle(2);
    chk("bad_ch1", int'(out_badpid[1]), 1);
    chk("bad_ch1_offs", int'(out_offs[7:4]), 7);
    chk("bad_ch1_bend", int'(out_bend[9:5]), 0);
    chk("bad_ch1_eskey", int'(out_eskey[ESW +: ESW]), 160);
    chk("bad_ch0", int'(out_badpid[0]), 0);
    chk("bad_ch0_eskey", int'(out_eskey[ESW-1:0]), 118);
    chk("bad_ch0_bend", int'(out_bend[4:0]), 8);
    idle(3);

    // reset right after a burst: in-flight candidates are dropped
    drive(0, 20, 0, 'h010); @(negedge clock);
    drive(0, 21, 0, 'h011); @(negedge clock);
    drive(0, 22, 0, 'h012); @(negedge clock);
    in_vld = '0; reset = 1'b1; @(negedge clock);
    reset = 1'b0; chk("rst_drop0", int'(out_vld), 0); @(negedge clock);
    chk("rst_drop1", int'(out_vld), 0); @(negedge clock);
    chk("rst_drop2", int'(out_vld), 0); drive(0, 33, 1, 'h020); @(negedge clock);
    in_vld = '0; chk("rst_wait1", int'(out_vld[0]), 0); @(negedge clock);
    chk("rst_wait2", int'(out_vld[0]), 0); @(negedge clock);
    chk("rst_first_vld", int'(out_vld[0]), 1);
    chk("rst_first_eskey", int'(out_eskey[ESW-1:0]), 125);
    idle(3);

`ifdef CCLUT_LUT_WRITE_EN
    // write lands on the same edge as the first lookup: old data, then new
    drive(0, 60, 3, 'h155); @(negedge clock);
    lut_we = 1'b1; lut_pid = 3'd3; lut_adr = 11'h155; lut_wdata = 9'h1FF; @(negedge clock);
    lut_pid = 3'd7; lut_wdata = '0; @(negedge clock);
    lut_we = 1'b0; in_vld = '0;
    chk("wr_old_offs", int'(out_offs[3:0]), 5);
    chk("wr_old_bend", int'(out_bend[4:0]), 'h16);
    @(negedge clock);
    chk("wr_new_offs", int'(out_offs[3:0]), 15);
    chk("wr_new_bend", int'(out_bend[4:0]), 'h1F);
    @(negedge clock);
    chk("wr_pid7_ignored", int'(out_bend[4:0]), 'h1F);
    idle(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
